// File: rtl/goa_bridge_pkg.sv
// Shared types and pin-map constants for the GOA pin bridge.
// Byte-count helper is used to size the serial shift registers.
package goa_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WR_ISSUE,
    RD_ISSUE,
    READ_WAIT,
    RESP,
    ERROR
  } state_t;

  localparam int UIO_VALID      = 0;
  localparam int UIO_ACK        = 1;
  localparam int UIO_ABORT      = 2;
  localparam int UIO_READY      = 1;
  localparam int UIO_RESP_VALID = 2;
  localparam int UIO_ERROR      = 3;

  localparam logic [7:0] UIO_OE_MASK   = 8'h0E;
  localparam int         CMD_WRITE_BIT = 7;

  function automatic int bytes_for(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/goa_sync_edge.sv
// Multi-flop synchroniser for an asynchronous host pin followed by a
// rising-edge detector; rise is a one-cycle pulse in the clk domain.
module goa_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/goa_pin_bridge.sv
// Byte-serial bridge from the TinyTapeout pin set to a wide register port.
// Host frames: command byte, address bytes, (write data bytes); MSB byte first.
module goa_pin_bridge
  import goa_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            ui_in,
  input  logic [7:0]            uio_in,
  output logic [7:0]            uo_out,
  output logic [7:0]            uio_out,
  output logic [7:0]            uio_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wen,
  output logic                  reg_ren,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_rvalid
);

  localparam int AB   = bytes_for(ADDR_WIDTH);
  localparam int DB   = bytes_for(DATA_WIDTH);
  localparam int ABW  = AB * 8;
  localparam int DBW  = DB * 8;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state;
  logic [3:0]      byte_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [ABW-1:0]  addr_sr;
  logic [DBW-1:0]  wdata_sr;
  logic [DBW-1:0]  rdata_sr;
  logic [DBW-1:0]  rdata_ext;
  logic [DBW-1:0]  rdata_next;
  logic [7:0]      uo_byte;
  logic            is_write;
  logic            ready;
  logic            resp_valid;
  logic            error;

  logic valid_rise;
  logic ack_rise;
  logic abort_rise;
  logic accept;
  logic unused_uio;

  goa_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_valid (
    .clk(clk), .rst_n(rst_n), .d(uio_in[UIO_VALID]), .rise(valid_rise)
  );
  goa_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk(clk), .rst_n(rst_n), .d(uio_in[UIO_ACK]), .rise(ack_rise)
  );
  goa_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_abort (
    .clk(clk), .rst_n(rst_n), .d(uio_in[UIO_ABORT]), .rise(abort_rise)
  );

  assign unused_uio = ^uio_in[7:3];
  assign accept     = valid_rise & ready;
  assign rdata_ext  = DBW'(reg_rdata);
  assign rdata_next = rdata_sr << 8;

  function automatic logic [ABW-1:0] shift_addr(input logic [ABW-1:0] cur,
                                                input logic [7:0] b);
    logic [ABW-1:0] t;
    t      = cur << 8;
    t[7:0] = b;
    return t;
  endfunction

  function automatic logic [DBW-1:0] shift_data(input logic [DBW-1:0] cur,
                                                input logic [7:0] b);
    logic [DBW-1:0] t;
    t      = cur << 8;
    t[7:0] = b;
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      addr_sr    <= '0;
      wdata_sr   <= '0;
      rdata_sr   <= '0;
      uo_byte    <= '0;
      is_write   <= 1'b0;
      ready      <= 1'b0;
      resp_valid <= 1'b0;
      error      <= 1'b0;
      reg_wen    <= 1'b0;
      reg_ren    <= 1'b0;
    end else begin
      reg_wen <= 1'b0;
      reg_ren <= 1'b0;
      if (abort_rise) begin
        // Abort beats everything, including a byte strobe in the same cycle.
        state      <= IDLE;
        byte_cnt   <= '0;
        uo_byte    <= '0;
        ready      <= 1'b1;
        resp_valid <= 1'b0;
        error      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ready <= 1'b1;
            if (accept) begin
              if (ui_in[6:0] != 7'd0) begin
                state <= ERROR;
                ready <= 1'b0;
                error <= 1'b1;
              end else begin
                is_write <= ui_in[CMD_WRITE_BIT];
                byte_cnt <= '0;
                state    <= ADDR;
              end
            end
          end
          ADDR: begin
            if (accept) begin
              addr_sr <= shift_addr(addr_sr, ui_in);
              if (byte_cnt == 4'(AB - 1)) begin
                byte_cnt <= '0;
                if (is_write) begin
                  state <= WDATA;
                end else begin
                  state <= RD_ISSUE;
                  ready <= 1'b0;
                end
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
              end
            end
          end
          WDATA: begin
            if (accept) begin
              wdata_sr <= shift_data(wdata_sr, ui_in);
              if (byte_cnt == 4'(DB - 1)) begin
                byte_cnt <= '0;
                state    <= WR_ISSUE;
                ready    <= 1'b0;
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
              end
            end
          end
          WR_ISSUE: begin
            reg_wen <= 1'b1;
            state   <= IDLE;
            ready   <= 1'b1;
          end
          RD_ISSUE: begin
            reg_ren <= 1'b1;
            to_cnt  <= '0;
            state   <= READ_WAIT;
          end
          READ_WAIT: begin
            // The first cycle here coincides with the reg_ren pulse.
            if (reg_rvalid) begin
              rdata_sr   <= rdata_ext;
              uo_byte    <= rdata_ext[DBW-1 -: 8];
              resp_valid <= 1'b1;
              byte_cnt   <= '0;
              state      <= RESP;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              error <= 1'b1;
              state <= ERROR;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          RESP: begin
            if (ack_rise) begin
              if (byte_cnt == 4'(DB - 1)) begin
                state      <= IDLE;
                resp_valid <= 1'b0;
                uo_byte    <= '0;
                ready      <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
                rdata_sr <= rdata_next;
                uo_byte  <= rdata_next[DBW-1 -: 8];
              end
            end
          end
          ERROR: begin
            error <= 1'b1;
            ready <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign reg_addr  = addr_sr[ADDR_WIDTH-1:0];
  assign reg_wdata = wdata_sr[DATA_WIDTH-1:0];
  assign uo_out    = uo_byte;
  assign uio_oe    = UIO_OE_MASK;

  always_comb begin
    uio_out                 = 8'h00;
    uio_out[UIO_READY]      = ready;
    uio_out[UIO_RESP_VALID] = resp_valid;
    uio_out[UIO_ERROR]      = error;
  end

endmodule

// File: tb/tb_goa_pin_bridge.sv
// Directed bench: 8/32 bridge (dut_a) and 12/20 bridge (dut_b) sharing host pins;
// the bridge not under test is held in reset.
module tb_goa_pin_bridge;

  logic        clk = 1'b0;
  logic        rst_n_a = 1'b0;
  logic        rst_n_b = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uio_in = 8'h00;
  logic [63:0] rsp_data = 64'h0;
  logic        reg_rvalid = 1'b0;
  logic        rsp_en = 1'b0;

  logic [7:0]  uo_out_a, uio_out_a, uio_oe_a;
  logic [7:0]  reg_addr_a;
  logic [31:0] reg_wdata_a;
  logic        reg_wen_a, reg_ren_a;

  logic [7:0]  uo_out_b, uio_out_b, uio_oe_b;
  logic [11:0] reg_addr_b;
  logic [19:0] reg_wdata_b;
  logic        reg_wen_b, reg_ren_b;

  int checks = 0;
  int errors = 0;
  int wen_cnt_a = 0, ren_cnt_a = 0, wen_cnt_b = 0;

  always #5 clk = ~clk;

  goa_pin_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out_a), .uio_out(uio_out_a), .uio_oe(uio_oe_a),
    .reg_addr(reg_addr_a), .reg_wdata(reg_wdata_a), .reg_wen(reg_wen_a), .reg_ren(reg_ren_a),
    .reg_rdata(rsp_data[31:0]), .reg_rvalid(reg_rvalid)
  );

  goa_pin_bridge #(.ADDR_WIDTH(12), .DATA_WIDTH(20), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out_b), .uio_out(uio_out_b), .uio_oe(uio_oe_b),
    .reg_addr(reg_addr_b), .reg_wdata(reg_wdata_b), .reg_wen(reg_wen_b), .reg_ren(reg_ren_b),
    .reg_rdata(rsp_data[19:0]), .reg_rvalid(reg_rvalid)
  );

  always @(posedge clk) begin
    if (reg_wen_a) wen_cnt_a <= wen_cnt_a + 1;
    if (reg_ren_a) ren_cnt_a <= ren_cnt_a + 1;
    if (reg_wen_b) wen_cnt_b <= wen_cnt_b + 1;
  end

  // Register-side model: answers a read three cycles after reg_ren.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_en && (reg_ren_a || reg_ren_b)) begin
        repeat (3) @(negedge clk);
        reg_rvalid = 1'b1;
        @(negedge clk);
        reg_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic strobe_on(input int idx, input logic [7:0] b);
    @(negedge clk);
    ui_in = b;
    uio_in[idx] = 1'b1;
  endtask

  task automatic strobe_off(input int idx);
    repeat (5) @(negedge clk);
    uio_in[idx] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    strobe_on(0, b);
    strobe_off(0);
  endtask

  task automatic pulse(input int idx);
    strobe_on(idx, ui_in);
    strobe_off(idx);
  endtask

  task automatic wait_resp_a(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (uio_out_a[2]) seen = 1'b1;
      else @(negedge clk);
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    int w0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_uo", uo_out_a, 8'h00);
    chk("rst_uio_out", uio_out_a, 8'h00);
    chk("rst_oe", uio_oe_a, 8'h0E);
    chk("rst_strobes", {reg_wen_a, reg_ren_a}, 2'b00);
    chk("rst_addr_data", {reg_addr_a, reg_wdata_a}, 40'h0);
    rst_n_a = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", uio_out_a[1], 1'b1);

    // Write frame with exact strobe latency
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'hDE);
    send_byte(8'hAD); send_byte(8'hBE);
    strobe_on(0, 8'hEF);
    repeat (3) @(negedge clk);
    chk("wen_early", reg_wen_a, 1'b0);
    @(negedge clk);
    chk("wen_pulse", reg_wen_a, 1'b1);
    chk("wr_addr", reg_addr_a, 8'h3C);
    chk("wr_data", reg_wdata_a, 32'hDEADBEEF);
    @(negedge clk);
    chk("wen_late", reg_wen_a, 1'b0);
    strobe_off(0);
    chk("wen_count", wen_cnt_a, 1);
    chk("wr_ready", uio_out_a[1], 1'b1);

    // Read frame, four response bytes
    rsp_en = 1'b1;
    rsp_data = 64'h12345678;
    send_byte(8'h00); send_byte(8'h3C);
    wait_resp_a("rd_resp_seen");
    chk("rd_b0", uo_out_a, 8'h12);
    chk("rd_ready0", uio_out_a[1], 1'b0);
    pulse(1); chk("rd_b1", uo_out_a, 8'h34);
    pulse(1); chk("rd_b2", uo_out_a, 8'h56);
    pulse(1); chk("rd_b3", {uio_out_a[2], uo_out_a}, 9'h178);
    pulse(1); chk("rd_done", {uio_out_a[2], uo_out_a}, 9'h000);
    chk("rd_ready", uio_out_a[1], 1'b1);
    chk("ren_count", ren_cnt_a, 1);

    // Read timeout
    rsp_en = 1'b0;
    send_byte(8'h00);
    strobe_on(0, 8'h3C);
    repeat (4) @(negedge clk);
    chk("to_ren", reg_ren_a, 1'b1);
    repeat (15) @(negedge clk);
    chk("to_not_yet", uio_out_a[3], 1'b0);
    @(negedge clk);
    chk("to_error", uio_out_a[3:1], 3'b100);
    uio_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    w0 = wen_cnt_a;
    send_byte(8'h80);
    chk("to_strobe_ignored", uio_out_a[3:1], 3'b100);
    pulse(2);
    chk("to_abort", uio_out_a[3:1], 3'b001);

    // Bad command
    send_byte(8'h81);
    chk("bad_error", uio_out_a[3:1], 3'b100);
    send_byte(8'h80);
    chk("bad_stays", uio_out_a[3], 1'b1);
    chk("bad_no_strobe", {wen_cnt_a, ren_cnt_a}, {w0, 32'd2});
    pulse(2);
    chk("bad_abort", uio_out_a[3:1], 3'b001);

    // Abort mid-write, then a clean frame
    send_byte(8'h80); send_byte(8'h01); send_byte(8'hAA);
    pulse(2);
    chk("abort_no_wen", wen_cnt_a, w0);
    chk("abort_ready", uio_out_a[3:1], 3'b001);
    send_byte(8'h80); send_byte(8'h55); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("after_abort_wen", wen_cnt_a, w0 + 1);
    chk("after_abort_wr", {reg_addr_a, reg_wdata_a}, 40'h55_01020304);

    // Reset during RESP
    rsp_en = 1'b1;
    rsp_data = 64'hCAFEF00D;
    send_byte(8'h00); send_byte(8'h77);
    wait_resp_a("rst_resp_seen");
    chk("rst_resp_b0", uo_out_a, 8'hCA);
    @(negedge clk);
    rst_n_a = 1'b0;
    #1;
    chk("midrst_uo", uo_out_a, 8'h00);
    chk("midrst_uio", uio_out_a, 8'h00);
    chk("midrst_oe", uio_oe_a, 8'h0E);
    chk("midrst_regs", {reg_wen_a, reg_ren_a, reg_addr_a, reg_wdata_a}, 42'h0);
    @(negedge clk);
    rst_n_a = 1'b1;
    @(negedge clk);
    chk("midrst_ready", uio_out_a[1], 1'b1);

    // 12-bit address / 20-bit data bridge
    rst_n_a = 1'b0;
    rst_n_b = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h80); send_byte(8'hFA); send_byte(8'hBC);
    send_byte(8'hF1); send_byte(8'h23); send_byte(8'h45);
    chk("w_wen_b", wen_cnt_b, 1);
    chk("w_addr_b", reg_addr_b, 12'hABC);
    chk("w_data_b", reg_wdata_b, 20'h12345);
    rsp_data = 64'hFFFF_FFFF_FFFA_BCDE;
    send_byte(8'h00); send_byte(8'h0F); send_byte(8'hFF);
    chk("r_addr_b", reg_addr_b, 12'hFFF);
    chk("r_b0_b", {uio_out_b[2], uo_out_b}, 9'h10A);
    pulse(1); chk("r_b1_b", uo_out_b, 8'hBC);
    pulse(1); chk("r_b2_b", uo_out_b, 8'hDE);
    pulse(1); chk("r_done_b", {uio_out_b[2:1], uo_out_b}, 10'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
